id_stage: RTL and testbench

//  Decode stage of the 5-stage LA32R pipeline, directly downstream of instruction fetch.
//  - Latches {pc, inst} from fetch and decodes a fixed instruction subset.
//  - Reads the register file through two external read ports and stalls on RAW hazards.
//  - Resolves branches and jumps, returns {br_taken, br_target} to fetch, and squashes the wrong-path slot.
//  - Hands a decoded bundle to EX with a valid/allow handshake.

---
 rtl/la32_pkg.sv | 82 ++++++++
 rtl/id_decode.sv | 123 ++++++++++++
 rtl/id_stage.sv | 110 +++++++++++
 tb/tb_id_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/la32_pkg.sv
// rtl/la32_pkg.sv - LA32R decode constants, ALU one-hot indices and ID->EX bundle layout
package la32_pkg;

  localparam int DST_W    = 6;
  localparam int ALU_OP_W = 12;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_OR   = 5;
  localparam int ALU_NOR  = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  localparam logic [16:0] OP_ADD_W  = 17'h00020;
  localparam logic [16:0] OP_SUB_W  = 17'h00022;
  localparam logic [16:0] OP_SLT    = 17'h00024;
  localparam logic [16:0] OP_SLTU   = 17'h00025;
  localparam logic [16:0] OP_NOR    = 17'h00028;
  localparam logic [16:0] OP_AND    = 17'h00029;
  localparam logic [16:0] OP_OR     = 17'h0002a;
  localparam logic [16:0] OP_XOR    = 17'h0002b;
  localparam logic [16:0] OP_SLLI_W = 17'h00081;
  localparam logic [16:0] OP_SRLI_W = 17'h00089;
  localparam logic [16:0] OP_SRAI_W = 17'h00091;
  localparam logic [9:0]  OP_ADDI_W = 10'h00a;
  localparam logic [9:0]  OP_LD_W   = 10'h0a2;
  localparam logic [9:0]  OP_ST_W   = 10'h0a6;
  localparam logic [6:0]  OP_LU12I_W = 7'h0a;
  localparam logic [5:0]  OP_JIRL   = 6'h13;
  localparam logic [5:0]  OP_B      = 6'h14;
  localparam logic [5:0]  OP_BL     = 6'h15;
  localparam logic [5:0]  OP_BEQ    = 6'h16;
  localparam logic [5:0]  OP_BNE    = 6'h17;

  localparam int F_PC_LSB   = 0;
  localparam int F_RKD_LSB  = 32;
  localparam int F_SRC2_LSB = 64;
  localparam int F_SRC1_LSB = 96;
  localparam int F_DEST_LSB = 128;
  localparam int F_RF_WE    = 133;
  localparam int F_ST       = 134;
  localparam int F_LD       = 135;
  localparam int F_ALU_LSB  = 136;
  localparam int ID_EX_WIDTH = 148;

  typedef enum logic [1:0] {
    SRC2_RK   = 2'd0,
    SRC2_IMM  = 2'd1,
    SRC2_FOUR = 2'd2
  } src2_sel_e;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                ld;
    logic                st;
    logic                rf_we;
    logic [4:0]          dest;
    logic [4:0]          raddr1;
    logic [4:0]          raddr2;
    logic                use_r1;
    logic                use_r2;
    logic                src1_pc;
    src2_sel_e           src2_sel;
    logic [31:0]         imm;
    logic [31:0]         br_offs;
    logic                jump;
    logic                is_jirl;
    logic                is_beq;
    logic                is_bne;
  } decode_t;

  function automatic logic dst_hit(logic [4:0] r, logic [DST_W-1:0] dst);
    return dst[DST_W-1] && (dst[4:0] == r);
  endfunction

endpackage

// File: rtl/id_decode.sv
// rtl/id_decode.sv - combinational LA32R subset decoder: controls, immediates, register indices
module id_decode
  import la32_pkg::*;
(
  input  logic [31:0] inst,
  output decode_t     dec
);

  logic [4:0]  rd, rj, rk;
  logic [16:0] op17;
  logic [9:0]  op10;
  logic [6:0]  op7;
  logic [5:0]  op6;
  logic [31:0] si12, ui5, si20, offs16, offs26;
  logic        rr, sh;

  assign rd     = inst[4:0];
  assign rj     = inst[9:5];
  assign rk     = inst[14:10];
  assign op17   = inst[31:15];
  assign op10   = inst[31:22];
  assign op7    = inst[31:25];
  assign op6    = inst[31:26];
  assign si12   = {{20{inst[21]}}, inst[21:10]};
  assign ui5    = {27'b0, inst[14:10]};
  assign si20   = {inst[24:5], 12'b0};
  assign offs16 = {{14{inst[25]}}, inst[25:10], 2'b00};
  assign offs26 = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};

  always_comb begin
    dec          = '0;
    dec.src2_sel = SRC2_RK;
    dec.raddr1   = rj;
    dec.raddr2   = rk;
    dec.dest     = rd;
    rr           = 1'b0;
    sh           = 1'b0;

    case (op17)
      OP_ADD_W:  begin rr = 1'b1; dec.alu_op[ALU_ADD]  = 1'b1; end
      OP_SUB_W:  begin rr = 1'b1; dec.alu_op[ALU_SUB]  = 1'b1; end
      OP_SLT:    begin rr = 1'b1; dec.alu_op[ALU_SLT]  = 1'b1; end
      OP_SLTU:   begin rr = 1'b1; dec.alu_op[ALU_SLTU] = 1'b1; end
      OP_NOR:    begin rr = 1'b1; dec.alu_op[ALU_NOR]  = 1'b1; end
      OP_AND:    begin rr = 1'b1; dec.alu_op[ALU_AND]  = 1'b1; end
      OP_OR:     begin rr = 1'b1; dec.alu_op[ALU_OR]   = 1'b1; end
      OP_XOR:    begin rr = 1'b1; dec.alu_op[ALU_XOR]  = 1'b1; end
      OP_SLLI_W: begin sh = 1'b1; dec.alu_op[ALU_SLL]  = 1'b1; end
      OP_SRLI_W: begin sh = 1'b1; dec.alu_op[ALU_SRL]  = 1'b1; end
      OP_SRAI_W: begin sh = 1'b1; dec.alu_op[ALU_SRA]  = 1'b1; end
      default: ;
    endcase

    if (rr) begin
      dec.rf_we  = 1'b1;
      dec.use_r1 = 1'b1;
      dec.use_r2 = 1'b1;
    end
    if (sh) begin
      dec.rf_we    = 1'b1;
      dec.use_r1   = 1'b1;
      dec.src2_sel = SRC2_IMM;
      dec.imm      = ui5;
    end

    // Stores read rd through port 2 so rkd carries the store data.
    case (op10)
      OP_ADDI_W, OP_LD_W: begin
        dec.alu_op[ALU_ADD] = 1'b1;
        dec.rf_we    = 1'b1;
        dec.ld       = (op10 == OP_LD_W);
        dec.use_r1   = 1'b1;
        dec.src2_sel = SRC2_IMM;
        dec.imm      = si12;
      end
      OP_ST_W: begin
        dec.alu_op[ALU_ADD] = 1'b1;
        dec.st       = 1'b1;
        dec.use_r1   = 1'b1;
        dec.use_r2   = 1'b1;
        dec.raddr2   = rd;
        dec.src2_sel = SRC2_IMM;
        dec.imm      = si12;
      end
      default: ;
    endcase

    if (op7 == OP_LU12I_W) begin
      dec.alu_op[ALU_LUI] = 1'b1;
      dec.rf_we    = 1'b1;
      dec.src2_sel = SRC2_IMM;
      dec.imm      = si20;
    end

    case (op6)
      OP_JIRL, OP_BL: begin
        dec.alu_op[ALU_ADD] = 1'b1;
        dec.rf_we    = 1'b1;
        dec.jump     = 1'b1;
        dec.src1_pc  = 1'b1;
        dec.src2_sel = SRC2_FOUR;
        dec.is_jirl  = (op6 == OP_JIRL);
        dec.use_r1   = (op6 == OP_JIRL);
        dec.dest     = (op6 == OP_BL) ? 5'd1 : rd;
        dec.br_offs  = (op6 == OP_BL) ? offs26 : offs16;
      end
      OP_B: begin
        dec.jump    = 1'b1;
        dec.br_offs = offs26;
      end
      OP_BEQ, OP_BNE: begin
        dec.is_beq  = (op6 == OP_BEQ);
        dec.is_bne  = (op6 == OP_BNE);
        dec.use_r1  = 1'b1;
        dec.use_r2  = 1'b1;
        dec.raddr2  = rd;
        dec.br_offs = offs16;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - LA32R decode stage: pipeline register, RAW stall, branch resolve, EX bundle
module id_stage
  import la32_pkg::*;
#(
  parameter int ID_EX_W  = 148,
  parameter bit CHECK_WB = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               if_to_id_valid,
  input  logic [63:0]        if_to_id_data,
  output logic               id_allow,
  output logic [32:0]        id_to_if_data,
  input  logic               ex_allow,
  output logic               id_to_ex_valid,
  output logic [ID_EX_W-1:0] id_to_ex_data,
  output logic [4:0]         rf_raddr1,
  output logic [4:0]         rf_raddr2,
  input  logic [31:0]        rf_rdata1,
  input  logic [31:0]        rf_rdata2,
  input  logic [DST_W-1:0]   ex_dst,
  input  logic [DST_W-1:0]   mem_dst,
  input  logic [DST_W-1:0]   wb_dst
);

  if (ID_EX_W != ID_EX_WIDTH) begin : g_bad_width
    $error("id_stage: ID_EX_W must match the package bundle layout");
  end

  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;

  decode_t          dec;
  logic [DST_W-1:0] wb_cmp;
  logic             r1_haz, r2_haz, stall, id_ready;
  logic             br_eq, br_taken;
  logic [31:0]      br_target, src1, src2;
  logic             rf_we;

  id_decode u_decode (
    .inst (id_inst_q),
    .dec  (dec)
  );

  assign rf_raddr1 = dec.raddr1;
  assign rf_raddr2 = dec.raddr2;

  // A write-through regfile makes the WB stage invisible to the hazard compare.
  assign wb_cmp = CHECK_WB ? wb_dst : '0;

  always_comb begin
    r1_haz = dec.use_r1 && (dec.raddr1 != 5'd0) &&
             (dst_hit(dec.raddr1, ex_dst) || dst_hit(dec.raddr1, mem_dst) ||
              dst_hit(dec.raddr1, wb_cmp));
    r2_haz = dec.use_r2 && (dec.raddr2 != 5'd0) &&
             (dst_hit(dec.raddr2, ex_dst) || dst_hit(dec.raddr2, mem_dst) ||
              dst_hit(dec.raddr2, wb_cmp));
    stall    = id_valid_q && (r1_haz || r2_haz);
    id_ready = !stall;
  end

  always_comb begin
    br_eq     = (rf_rdata1 == rf_rdata2);
    br_taken  = id_valid_q && id_ready &&
                (dec.jump || (dec.is_beq && br_eq) || (dec.is_bne && !br_eq));
    br_target = (dec.is_jirl ? rf_rdata1 : id_pc_q) + dec.br_offs;
  end

  always_comb begin
    src1 = dec.src1_pc ? id_pc_q : rf_rdata1;
    case (dec.src2_sel)
      SRC2_IMM:  src2 = dec.imm;
      SRC2_FOUR: src2 = 32'd4;
      default:   src2 = rf_rdata2;
    endcase
    rf_we = dec.rf_we && (dec.dest != 5'd0);
  end

  assign id_allow       = !id_valid_q || (id_ready && ex_allow);
  assign id_to_ex_valid = id_valid_q && id_ready;
  assign id_to_if_data  = {br_taken, br_target};
  assign id_to_ex_data  = {dec.alu_op, dec.ld, dec.st, rf_we, dec.dest,
                           src1, src2, rf_rdata2, id_pc_q};

  // A taken branch squashes whatever fetch offers on the same edge.
  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    if (id_allow) begin
      id_valid_d = if_to_id_valid && !br_taken;
      id_pc_d    = if_to_id_data[63:32];
      id_inst_d  = if_to_id_data[31:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= 32'd0;
      id_inst_q  <= 32'd0;
    end else begin
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         if_to_id_valid;
  logic [63:0]  if_to_id_data;
  logic         id_allow;
  logic [32:0]  id_to_if_data;
  logic         ex_allow;
  logic         id_to_ex_valid;
  logic [147:0] id_to_ex_data;
  logic [4:0]   rf_raddr1, rf_raddr2;
  logic [31:0]  rf_rdata1, rf_rdata2;
  logic [5:0]   ex_dst, mem_dst, wb_dst;

  logic [31:0] rf [0:31];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  id_stage #(.ID_EX_W(148), .CHECK_WB(1'b1)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .if_to_id_valid (if_to_id_valid),
    .if_to_id_data  (if_to_id_data),
    .id_allow       (id_allow),
    .id_to_if_data  (id_to_if_data),
    .ex_allow       (ex_allow),
    .id_to_ex_valid (id_to_ex_valid),
    .id_to_ex_data  (id_to_ex_data),
    .rf_raddr1      (rf_raddr1),
    .rf_raddr2      (rf_raddr2),
    .rf_rdata1      (rf_rdata1),
    .rf_rdata2      (rf_rdata2),
    .ex_dst         (ex_dst),
    .mem_dst        (mem_dst),
    .wb_dst         (wb_dst)
  );

  wire [11:0] b_alu  = id_to_ex_data[147:136];
  wire [2:0]  b_lsw  = id_to_ex_data[135:133];
  wire        b_we   = id_to_ex_data[133];
  wire [4:0]  b_dest = id_to_ex_data[132:128];
  wire [31:0] b_src1 = id_to_ex_data[127:96];
  wire [31:0] b_src2 = id_to_ex_data[95:64];
  wire [31:0] b_rkd  = id_to_ex_data[63:32];
  wire [31:0] b_pc   = id_to_ex_data[31:0];
  wire        br_tk  = id_to_if_data[32];
  wire [31:0] br_tg  = id_to_if_data[31:0];

  function automatic logic [31:0] enc_rr(logic [16:0] op, logic [4:0] rk, logic [4:0] rj, logic [4:0] rd);
    return {op, rk, rj, rd};
  endfunction
  function automatic logic [31:0] enc_i12(logic [9:0] op, logic [11:0] si, logic [4:0] rj, logic [4:0] rd);
    return {op, si, rj, rd};
  endfunction
  function automatic logic [31:0] enc_o16(logic [5:0] op, logic [15:0] offs, logic [4:0] rj, logic [4:0] rd);
    return {op, offs, rj, rd};
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] pc, input logic [31:0] inst);
    if_to_id_valid = 1'b1;
    if_to_id_data  = {pc, inst};
    cyc();
    if_to_id_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; if_to_id_valid = 1'b0; if_to_id_data = '0; ex_allow = 1'b1;
    ex_dst = '0; mem_dst = '0; wb_dst = '0;
    repeat (2) cyc();
    n_cmp++; if (id_allow !== 1'b1) begin n_bad++; $display("FAIL rst_allow got %b want 1", id_allow); end
    n_cmp++; if (id_to_ex_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", id_to_ex_valid); end
    n_cmp++; if (br_tk !== 1'b0) begin n_bad++; $display("FAIL rst_br got %b want 0", br_tk); end
    resetn = 1'b1;
    mem_dst = {1'b1, 5'd1};
    feed(32'h1c000000, enc_rr(17'h20, 5'd2, 5'd1, 5'd3));
    n_cmp++; if (id_allow !== 1'b0) begin n_bad++; $display("FAIL rst_prestall got %b want 0", id_allow); end
    resetn = 1'b0;
    #1;
    n_cmp++; if (id_to_ex_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b want 0", id_to_ex_valid); end
    n_cmp++; if (id_allow !== 1'b1) begin n_bad++; $display("FAIL midrst_allow got %b want 1", id_allow); end
    n_cmp++; if (br_tk !== 1'b0) begin n_bad++; $display("FAIL midrst_br got %b want 0", br_tk); end
    cyc();
    resetn = 1'b1; mem_dst = '0;
    if_to_id_valid = 1'b1; if_to_id_data = {32'h1c000004, enc_rr(17'h20, 5'd2, 5'd1, 5'd3)};
    #1;
    n_cmp++; if (id_to_ex_valid !== 1'b0) begin n_bad++; $display("FAIL first_early got %b want 0", id_to_ex_valid); end
    cyc();
    if_to_id_valid = 1'b0;
    #1;
    n_cmp++; if (id_to_ex_valid !== 1'b1) begin n_bad++; $display("FAIL first_valid got %b want 1", id_to_ex_valid); end
    n_cmp++; if (b_pc !== 32'h1c000004) begin n_bad++; $display("FAIL first_pc got %h want 1c000004", b_pc); end
    cyc();
  endtask

  task automatic test_add;
    feed(32'h1c000100, enc_rr(17'h20, 5'd2, 5'd1, 5'd3));
    n_cmp++; if (id_to_ex_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid got %b want 1", id_to_ex_valid); end
    n_cmp++; if (b_src1 !== 32'd5) begin n_bad++; $display("FAIL add_src1 got %0d want 5", b_src1); end
    n_cmp++; if (b_src2 !== 32'd7) begin n_bad++; $display("FAIL add_src2 got %0d want 7", b_src2); end
    n_cmp++; if (b_dest !== 5'd3) begin n_bad++; $display("FAIL add_dest got %0d want 3", b_dest); end
    n_cmp++; if (b_we !== 1'b1) begin n_bad++; $display("FAIL add_we got %b want 1", b_we); end
    n_cmp++; if (b_alu !== 12'h001) begin n_bad++; $display("FAIL add_alu got %h want 001", b_alu); end
    cyc();
    feed(32'h1c000104, enc_i12(10'h0a2, 12'hffc, 5'd1, 5'd5));
    n_cmp++; if (b_src2 !== 32'hfffffffc) begin n_bad++; $display("FAIL ld_imm got %h want fffffffc", b_src2); end
    n_cmp++; if (b_lsw !== 3'b101) begin n_bad++; $display("FAIL ld_ctl got %b want 101", b_lsw); end
    cyc();
  endtask

  task automatic test_raw;
    mem_dst = {1'b1, 5'd1};
    if_to_id_valid = 1'b1; if_to_id_data = {32'h1c000200, enc_rr(17'h20, 5'd2, 5'd1, 5'd3)};
    cyc();
    if_to_id_data = {32'h1c000204, enc_rr(17'h20, 5'd6, 5'd5, 5'd3)};
    #1;
    n_cmp++; if (id_allow !== 1'b0) begin n_bad++; $display("FAIL raw_allow got %b want 0", id_allow); end
    n_cmp++; if (id_to_ex_valid !== 1'b0) begin n_bad++; $display("FAIL raw_valid got %b want 0", id_to_ex_valid); end
    cyc();
    n_cmp++; if (b_pc !== 32'h1c000200) begin n_bad++; $display("FAIL raw_pchold got %h want 1c000200", b_pc); end
    mem_dst = '0;
    #1;
    n_cmp++; if (id_to_ex_valid !== 1'b1) begin n_bad++; $display("FAIL raw_release got %b want 1", id_to_ex_valid); end
    cyc();
    if_to_id_valid = 1'b0;
    #1;
    n_cmp++; if (b_pc !== 32'h1c000204) begin n_bad++; $display("FAIL raw_next got %h want 1c000204", b_pc); end
    cyc();
    ex_dst = {1'b1, 5'd0}; mem_dst = {1'b1, 5'd0};
    feed(32'h1c000208, enc_rr(17'h20, 5'd0, 5'd0, 5'd3));
    n_cmp++; if (id_to_ex_valid !== 1'b1 || id_allow !== 1'b1) begin n_bad++; $display("FAIL raw_r0 got %b%b want 11", id_to_ex_valid, id_allow); end
    cyc();
    ex_dst = {1'b1, 5'd1}; mem_dst = {1'b1, 5'd1}; wb_dst = {1'b1, 5'd1};
    feed(32'h1c00020c, enc_rr(17'h20, 5'd2, 5'd1, 5'd3));
    ex_dst = '0;
    cyc();
    mem_dst = '0;
    cyc();
    n_cmp++; if (id_to_ex_valid !== 1'b0) begin n_bad++; $display("FAIL raw_wbhold got %b want 0", id_to_ex_valid); end
    wb_dst = '0;
    #1;
    n_cmp++; if (id_to_ex_valid !== 1'b1) begin n_bad++; $display("FAIL raw_wbclr got %b want 1", id_to_ex_valid); end
    cyc();
  endtask

  task automatic test_branch;
    if_to_id_valid = 1'b1; if_to_id_data = {32'h1c000010, enc_o16(6'h16, 16'd4, 5'd8, 5'd9)};
    cyc();
    if_to_id_data = {32'h1c000014, enc_rr(17'h20, 5'd2, 5'd1, 5'd3)};
    #1;
    n_cmp++; if (br_tk !== 1'b1) begin n_bad++; $display("FAIL beq_taken got %b want 1", br_tk); end
    n_cmp++; if (br_tg !== 32'h1c000020) begin n_bad++; $display("FAIL beq_target got %h want 1c000020", br_tg); end
    n_cmp++; if (b_we !== 1'b0) begin n_bad++; $display("FAIL beq_we got %b want 0", b_we); end
    cyc();
    if_to_id_valid = 1'b0;
    #1;
    n_cmp++; if (id_to_ex_valid !== 1'b0) begin n_bad++; $display("FAIL beq_squash got %b want 0", id_to_ex_valid); end
    feed(32'h1c000030, enc_o16(6'h17, 16'd4, 5'd8, 5'd9));
    n_cmp++; if (br_tk !== 1'b0 || id_to_ex_valid !== 1'b1) begin n_bad++; $display("FAIL bne_eq got %b%b want 01", br_tk, id_to_ex_valid); end
    cyc();
    feed(32'h1c000000, 32'h53ffffff);
    n_cmp++; if (br_tk !== 1'b1 || br_tg !== 32'h1bfffffc) begin n_bad++; $display("FAIL b_back got %b %h want 1 1bfffffc", br_tk, br_tg); end
    cyc();
  endtask

  task automatic test_jirl;
    feed(32'h1c000200, enc_o16(6'h13, 16'h0010, 5'd4, 5'd1));
    n_cmp++; if (br_tk !== 1'b1 || br_tg !== 32'h1c001040) begin n_bad++; $display("FAIL jirl_br got %b %h want 1 1c001040", br_tk, br_tg); end
    n_cmp++; if (b_src1 !== 32'h1c000200) begin n_bad++; $display("FAIL jirl_src1 got %h want 1c000200", b_src1); end
    n_cmp++; if (b_src2 !== 32'd4) begin n_bad++; $display("FAIL jirl_src2 got %h want 4", b_src2); end
    n_cmp++; if (b_dest !== 5'd1 || b_we !== 1'b1) begin n_bad++; $display("FAIL jirl_dest got %0d/%b want 1/1", b_dest, b_we); end
    ex_allow = 1'b0;
    cyc();
    n_cmp++; if (br_tk !== 1'b1 || id_allow !== 1'b0) begin n_bad++; $display("FAIL jirl_held got %b%b want 10", br_tk, id_allow); end
    ex_allow = 1'b1;
    cyc();
  endtask

  task automatic test_back_to_back;
    logic [147:0] exp;
    exp = {12'h001, 1'b0, 1'b0, 1'b1, 5'd3, 32'd5, 32'd7, 32'd7, 32'h1c000300};
    ex_allow = 1'b0;
    feed(32'h1c000300, enc_rr(17'h20, 5'd2, 5'd1, 5'd3));
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (id_to_ex_valid !== 1'b1 || id_allow !== 1'b0) begin n_bad++; $display("FAIL bp_hs%0d got %b%b want 10", i, id_to_ex_valid, id_allow); end
      n_cmp++; if (id_to_ex_data !== exp) begin n_bad++; $display("FAIL bp_data%0d got %h want %h", i, id_to_ex_data, exp); end
      cyc();
    end
    ex_allow = 1'b1;
    #1;
    n_cmp++; if (id_allow !== 1'b1) begin n_bad++; $display("FAIL bp_release got %b want 1", id_allow); end
    cyc();
    feed(32'h1c000400, 32'hffffffff);
    n_cmp++; if (id_to_ex_valid !== 1'b1) begin n_bad++; $display("FAIL unk_valid got %b want 1", id_to_ex_valid); end
    n_cmp++; if (b_lsw !== 3'b000 || br_tk !== 1'b0) begin n_bad++; $display("FAIL unk_ctl got %b/%b want 000/0", b_lsw, br_tk); end
    cyc();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    rf[4] = 32'h1c001000;
    rf[5] = 32'd11;
    rf[6] = 32'd13;
    rf[8] = 32'h55;
    rf[9] = 32'h55;
    test_reset();
    test_add();
    test_raw();
    test_branch();
    test_jirl();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
